// File: rtl/sram_1rw1r_ctrl.sv
// ----------------------------------------------------------------------------
// sram_1rw1r_ctrl
//
// Initiator-side controller for a 1RW1R OpenRAM macro (32x512 by default).
// Turns a valid/ready request channel into registered port-0 macro pins and
// returns read data, in request order, on a valid/ready response channel.
// After reset the whole array is swept to zero before any request is taken.
//
// Optional feature macro: SRAM_CTRL_PORT1_EN
//   Defined   : adds a second read-only channel on macro port 1 (rd1_*).
//   Undefined : csb1 held 1, addr1 held 0, dout1 ignored.
//
// Ports
//   clk0, rst0          clock (shared with macro clk0/clk1), sync active-high reset
//   req_valid/ready     request handshake; req_we selects write(1)/read(0)
//   req_wmask/addr/wdata request payload (wmask/wdata used by writes only)
//   resp_valid/ready    read-response handshake, resp_rdata payload
//   init_done           zero sweep complete
//   csb0/web0/wmask0/addr0/din0, dout0   macro port 0 (active-low selects)
//   csb1/addr1, dout1                    macro port 1 (read only)
//   rd1_* (optional)    port-1 read request/response channels
// ----------------------------------------------------------------------------
module sram_1rw1r_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned NUM_WMASKS = 4,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
`ifdef SRAM_CTRL_PORT1_EN
  input  logic                  rd1_valid,
  output logic                  rd1_ready,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_resp_valid,
  input  logic                  rd1_resp_ready,
  output logic [DATA_WIDTH-1:0] rd1_rdata,
`endif
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef SRAM_CTRL_PORT1_EN
  localparam int unsigned NPORT = 2;
`else
  localparam int unsigned NPORT = 1;
`endif
  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Control / macro pin registers
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic                  r_init_done;
  logic                  r_csb0;
  logic                  r_web0;
  logic [NUM_WMASKS-1:0] r_wmask0;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [DATA_WIDTH-1:0] r_din0;
  logic                  r_csb1;
  logic [ADDR_WIDTH-1:0] r_addr1;

  // Per-port read pipeline and response FIFO
  logic [NPORT-1:0]      r_s1;   // read presented to macro, captured next edge
  logic [NPORT-1:0]      r_s2;   // macro dout valid, pushed next edge
  logic [NPORT-1:0]      r_rv;
  logic [DATA_WIDTH-1:0] r_fifo  [NPORT][RESP_DEPTH];
  logic [PTR_W-1:0]      r_wp    [NPORT];
  logic [PTR_W-1:0]      r_rp    [NPORT];
  logic [CNT_W-1:0]      r_cnt   [NPORT];
  logic [DATA_WIDTH-1:0] r_rdata [NPORT];

  logic                  w_run;
  logic                  w_acc0;
  logic [NPORT-1:0]      w_credit;
  logic [NPORT-1:0]      w_acc_rd;
  logic [NPORT-1:0]      w_pop;
  logic [NPORT-1:0]      w_resp_rdy;
  logic [DATA_WIDTH-1:0] w_dout     [NPORT];
  logic [CRD_W-1:0]      w_used     [NPORT];
  logic [PTR_W-1:0]      w_rp_nxt   [NPORT];
  logic [CNT_W-1:0]      w_cnt_nxt  [NPORT];
  logic [DATA_WIDTH-1:0] w_head_nxt [NPORT];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Gather per-port macro data and consumer ready into arrays
  always_comb begin
    w_resp_rdy    = '0;
    w_dout[0]     = dout0;
    w_resp_rdy[0] = resp_ready;
`ifdef SRAM_CTRL_PORT1_EN
    w_dout[1]     = dout1;
    w_resp_rdy[1] = rd1_resp_ready;
`endif
  end

  // Read credit: reads in flight plus buffered responses must leave a free slot.
  // A pop in the same cycle is deliberately not credited.
  always_comb begin
    w_credit = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      w_used[p]   = CRD_W'(r_cnt[p]) + CRD_W'(r_s1[p]) + CRD_W'(r_s2[p]);
      w_credit[p] = (w_used[p] < CRD_W'(RESP_DEPTH));
    end
  end

  assign w_run     = (r_state == ST_RUN);
  assign req_ready = w_run && (req_we || w_credit[0]);
  assign w_acc0    = req_valid && req_ready;

`ifdef SRAM_CTRL_PORT1_EN
  // Port 1 backs off while port 0 writes the same word this cycle
  assign rd1_ready = w_run && w_credit[1] &&
                     !(w_acc0 && req_we && (req_addr == rd1_addr));
`endif

  always_comb begin
    w_acc_rd    = '0;
    w_acc_rd[0] = w_acc0 && !req_we;
`ifdef SRAM_CTRL_PORT1_EN
    w_acc_rd[1] = rd1_valid && rd1_ready;
`endif
  end

  // FIFO next-state; a push into an empty-after-pop FIFO goes straight to head
  always_comb begin
    w_pop = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      w_pop[p]      = r_rv[p] && w_resp_rdy[p];
      w_rp_nxt[p]   = w_pop[p] ? ptr_inc(r_rp[p]) : r_rp[p];
      w_cnt_nxt[p]  = r_cnt[p] - CNT_W'(w_pop[p]) + CNT_W'(r_s2[p]);
      w_head_nxt[p] = (r_s2[p] && (r_cnt[p] == CNT_W'(w_pop[p])))
                      ? w_dout[p] : r_fifo[p][w_rp_nxt[p]];
    end
  end

  // Sweep/run FSM, macro pins and response path
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_state     <= ST_INIT;
      r_sweep     <= '0;
      r_init_done <= 1'b0;
      r_csb0      <= 1'b1;
      r_web0      <= 1'b1;
      r_wmask0    <= '0;
      r_addr0     <= '0;
      r_din0      <= '0;
      r_csb1      <= 1'b1;
      r_addr1     <= '0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_rv        <= '0;
      for (int unsigned p = 0; p < NPORT; p++) begin
        r_wp[p]    <= '0;
        r_rp[p]    <= '0;
        r_cnt[p]   <= '0;
        r_rdata[p] <= '0;
      end
    end else begin
      case (r_state)
        ST_INIT: begin
          r_csb0   <= 1'b0;
          r_web0   <= 1'b0;
          r_wmask0 <= '1;
          r_din0   <= '0;
          r_addr0  <= r_sweep;
          r_sweep  <= r_sweep + ADDR_WIDTH'(1);
          if (r_sweep == LAST_ADDR) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_acc0) begin
            r_csb0  <= 1'b0;
            r_web0  <= ~req_we;
            r_addr0 <= req_addr;
            if (req_we) begin
              r_wmask0 <= req_wmask;
              r_din0   <= req_wdata;
            end
          end else begin
            r_csb0 <= 1'b1;
            r_web0 <= 1'b1;
          end
`ifdef SRAM_CTRL_PORT1_EN
          if (w_acc_rd[1]) begin
            r_csb1  <= 1'b0;
            r_addr1 <= rd1_addr;
          end else begin
            r_csb1 <= 1'b1;
          end
`endif
        end
        default: r_state <= ST_INIT;
      endcase

      r_s1 <= w_acc_rd;
      r_s2 <= r_s1;
      for (int unsigned p = 0; p < NPORT; p++) begin
        if (r_s2[p]) begin
          r_fifo[p][r_wp[p]] <= w_dout[p];
          r_wp[p]            <= ptr_inc(r_wp[p]);
        end
        r_rp[p]  <= w_rp_nxt[p];
        r_cnt[p] <= w_cnt_nxt[p];
        r_rv[p]  <= (w_cnt_nxt[p] != '0);
        if (w_cnt_nxt[p] != '0) begin
          r_rdata[p] <= w_head_nxt[p];
        end
      end
    end
  end

  assign init_done  = r_init_done;
  assign csb0       = r_csb0;
  assign web0       = r_web0;
  assign wmask0     = r_wmask0;
  assign addr0      = r_addr0;
  assign din0       = r_din0;
  assign csb1       = r_csb1;
  assign addr1      = r_addr1;
  assign resp_valid = r_rv[0];
  assign resp_rdata = r_rdata[0];

`ifdef SRAM_CTRL_PORT1_EN
  assign rd1_resp_valid = r_rv[1];
  assign rd1_rdata      = r_rdata[1];
`else
  // Port 1 data is not consumed when the second channel is absent
  logic w_unused_dout1;
  assign w_unused_dout1 = ^dout1;
`endif

endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_1rw1r_ctrl
//
// Bench for sram_1rw1r_ctrl. Contains a cycle model of the 1RW1R macro
// (inputs captured on clk edge, dout updated at that edge) and a word-level
// reference: a memory array updated at request acceptance and a queue of
// expected read data in acceptance order.
// ----------------------------------------------------------------------------
module tb_sram_1rw1r_ctrl;

  logic        clk0;
  logic        rst0;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_wmask;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        init_done;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic        csb1;
  logic [8:0]  addr1;
  logic [31:0] dout1;
`ifdef SRAM_CTRL_PORT1_EN
  logic        rd1_valid;
  logic        rd1_ready;
  logic [8:0]  rd1_addr;
  logic        rd1_resp_valid;
  logic        rd1_resp_ready;
  logic [31:0] rd1_rdata;
`endif

  sram_1rw1r_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (9),
    .NUM_WMASKS (4),
    .RESP_DEPTH (4)
  ) dut (
    .clk0           (clk0),
    .rst0           (rst0),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_wmask      (req_wmask),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .init_done      (init_done),
    .csb0           (csb0),
    .web0           (web0),
    .wmask0         (wmask0),
    .addr0          (addr0),
    .din0           (din0),
    .dout0          (dout0),
`ifdef SRAM_CTRL_PORT1_EN
    .rd1_valid      (rd1_valid),
    .rd1_ready      (rd1_ready),
    .rd1_addr       (rd1_addr),
    .rd1_resp_valid (rd1_resp_valid),
    .rd1_resp_ready (rd1_resp_ready),
    .rd1_rdata      (rd1_rdata),
`endif
    .csb1           (csb1),
    .addr1          (addr1),
    .dout1          (dout1)
  );

  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  // Macro model: pins captured at the clock edge, read data visible after it
  logic [31:0] mem [512];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    dout0 = 32'h0;
    dout1 = 32'h0;
  end

  always @(posedge clk0) begin
    logic [31:0] w;
    if (csb0 === 1'b0) begin
      if (web0 === 1'b0) begin
        w = mem[addr0];
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) w[8*b +: 8] = din0[8*b +: 8];
        mem[addr0] <= w;
      end else begin
        dout0 <= mem[addr0];
      end
    end
    if (csb1 === 1'b0) dout1 <= mem[addr1];
  end

  // Reference model and bookkeeping
  logic [31:0] ref_mem [512];
  logic [31:0] exp_q [$];
  logic        last_acc;
  logic [31:0] last_rdata;
  int          n_pop;
  int          n_tests;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] m,
                       input logic [8:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_wmask = m;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  // One clock: observe handshakes at the negedge, update the reference,
  // then return 1 time unit after the next posedge.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk0);
    if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("resp_spurious", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", resp_rdata, e);
      end
      last_rdata = resp_rdata;
      n_pop++;
    end
    last_acc = (req_valid === 1'b1) && (req_ready === 1'b1);
    if (last_acc) begin
      if (req_we) begin
        for (int b = 0; b < 4; b++)
          if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end else begin
        exp_q.push_back(ref_mem[req_addr]);
      end
    end
    @(posedge clk0);
    #1;
  endtask

  // Called right after a reset edge with rst0 released: checks the 512-write sweep
  task automatic sweep();
    int bad;
    int early;
    bad   = 0;
    early = 0;
    req_we = 1'b1;
    for (int i = 0; i < 512; i++) begin
      cycle();
      if (csb0 !== 1'b0 || web0 !== 1'b0 || wmask0 !== 4'hF ||
          din0 !== 32'h0 || addr0 !== 9'(i)) bad++;
      if (resp_valid !== 1'b0 || csb1 !== 1'b1) bad++;
      if (i < 511 && (init_done !== 1'b0 || req_ready !== 1'b0)) early++;
    end
    check("sweep_pins", bad, 0);
    check("init_early", early, 0);
    check("init_done", init_done, 1'b1);
    req_we = 1'b0;
    #1;
    check("run_rd_ready", req_ready, 1'b1);
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic drain();
    idle();
    resp_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
    check("drain", exp_q.size(), 0);
    cycle();
    check("drain_idle", resp_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nacc;
    int n0;
    logic [31:0] hold_d;
    n_tests    = 0;
    n_fail     = 0;
    n_pop      = 0;
    last_acc   = 1'b0;
    last_rdata = 32'h0;
    rst0       = 1'b1;
    resp_ready = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
`ifdef SRAM_CTRL_PORT1_EN
    rd1_valid      = 1'b0;
    rd1_addr       = 9'h0;
    rd1_resp_ready = 1'b1;
`endif

    // Reset state
    repeat (3) cycle();
    check("rst_csb0", csb0, 1'b1);
    check("rst_web0", web0, 1'b1);
    check("rst_wmask0", wmask0, 4'h0);
    check("rst_addr0", addr0, 9'h0);
    check("rst_din0", din0, 32'h0);
    check("rst_csb1", csb1, 1'b1);
    check("rst_addr1", addr1, 9'h0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_init_done", init_done, 1'b0);
    req_we = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 1'b0);

    rst0 = 1'b0;
    sweep();

    // Top word cleared by the sweep
    resp_ready = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 9'h1FF, 32'h0);
    cycle();
    drain();
    check("sweep_1ff", last_rdata, 32'h0);

    // Write then read next cycle: 2-cycle latency, new data
    drive(1'b1, 1'b1, 4'hF, 9'h005, 32'hDEADBEEF);
    cycle();
    check("raw_wr_acc", last_acc, 1'b1);
    drive(1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
    cycle();
    check("raw_rd_acc", last_acc, 1'b1);
    idle();
    check("lat_e0", resp_valid, 1'b0);
    cycle();
    check("lat_e1", resp_valid, 1'b0);
    cycle();
    check("lat_e2", resp_valid, 1'b1);
    check("lat_data", resp_rdata, 32'hDEADBEEF);
    drain();

    // Partial byte-mask write
    drive(1'b1, 1'b1, 4'hF, 9'h010, 32'hAAAAAAAA);
    cycle();
    drive(1'b1, 1'b1, 4'b0101, 9'h010, 32'h11223344);
    cycle();
    drive(1'b1, 1'b1, 4'h0, 9'h010, 32'h55555555);
    cycle();
    drive(1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
    cycle();
    drain();
    check("wmask_merge", last_rdata, 32'hAA22AA44);

    // Distinct contents for addresses 0..127
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, 1'b1, 4'hF, 9'(i), $urandom);
      cycle();
    end
    idle();

    // Backpressure: only RESP_DEPTH reads accepted, writes still pass
    resp_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 4'h0, 9'(9'h040 + 9'(nacc)), 32'h0);
      cycle();
      if (last_acc) nacc++;
    end
    check("bp_reads_acc", nacc, 4);
    drive(1'b1, 1'b0, 4'h0, 9'h050, 32'h0);
    #1;
    check("bp_rd_ready", req_ready, 1'b0);
    drive(1'b1, 1'b1, 4'hF, 9'h070, 32'h12345678);
    #1;
    check("bp_wr_ready", req_ready, 1'b1);
    cycle();
    check("bp_wr_acc", last_acc, 1'b1);
    idle();
    check("bp_valid", resp_valid, 1'b1);
    hold_d = resp_rdata;
    cycle();
    cycle();
    check("bp_hold_valid", resp_valid, 1'b1);
    check("bp_hold_data", resp_rdata, hold_d);
    n0 = n_pop;
    drain();
    check("bp_resp_cnt", n_pop - n0, 4);

    // Back-to-back reads with the consumer always ready
    resp_ready = 1'b1;
    nacc = 0;
    n0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b0, 4'h0, 9'(i), 32'h0);
      cycle();
      if (last_acc) nacc++;
    end
    check("b2b_acc", nacc, 100);
    drain();
    check("b2b_resp_cnt", n_pop - n0, 100);

`ifdef SRAM_CTRL_PORT1_EN
    // Port-1 read colliding with a port-0 write to the same word
    drive(1'b1, 1'b1, 4'hF, 9'h020, 32'hCAFEF00D);
    rd1_valid = 1'b1;
    rd1_addr  = 9'h020;
    #1;
    check("p1_collide", rd1_ready, 1'b0);
    cycle();
    idle();
    #1;
    check("p1_ready", rd1_ready, 1'b1);
    cycle();
    rd1_valid = 1'b0;
    for (int i = 0; i < 8 && rd1_resp_valid !== 1'b1; i++) cycle();
    check("p1_valid", rd1_resp_valid, 1'b1);
    check("p1_data", rd1_rdata, 32'hCAFEF00D);
    cycle();
`endif

    // Randomized mixed traffic over a small address window
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
            9'($urandom_range(0, 31)), $urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Reset with reads in flight and buffered: all discarded
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 9'h003, 32'h0);
    cycle();
    cycle();
    idle();
    rst0 = 1'b1;
    cycle();
    exp_q.delete();
    rst0 = 1'b0;
    check("flush_valid", resp_valid, 1'b0);

    // Reset again part-way through the sweep
    for (int i = 0; i < 201; i++) cycle();
    check("mid_addr", addr0, 9'd200);
    check("mid_valid", resp_valid, 1'b0);
    rst0 = 1'b1;
    cycle();
    check("mid_rst_csb0", csb0, 1'b1);
    check("mid_rst_addr0", addr0, 9'h0);
    check("mid_rst_init", init_done, 1'b0);
    rst0 = 1'b0;
    sweep();

    // Post-reset traffic against a fresh zeroed array
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
            9'($urandom_range(0, 511)), $urandom);
      resp_ready = ($urandom_range(0, 1) != 0);
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
